// File: rtl/decoder_dispatch_2x4_pkg.sv
// decoder_dispatch_2x4_pkg: shared state encoding and default parameters
package decoder_dispatch_2x4_pkg;
   typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_e;
   localparam int N_DEF = 4;
   localparam int W_DEF = 2;
   localparam int TIMEOUT_DEF = 15;
   localparam int TW_DEF = 8;
endpackage

// File: rtl/decoder_dispatch_2x4_if.sv
// decoder_dispatch_2x4_if: request/grant/ack bundle between requester, dispatcher and targets
interface decoder_dispatch_2x4_if
   import decoder_dispatch_2x4_pkg::*;
#(parameter int N = N_DEF, parameter int W = W_DEF);
   logic         in_valid;
   logic [W-1:0] in_idx;
   logic         in_ready;
   logic [N-1:0] grant;
   logic [N-1:0] ack;
   logic         done;
   logic         err_timeout;
   logic         err_range;
   logic         busy;
   modport slave (input in_valid, in_idx, ack, output in_ready, grant, done, err_timeout, err_range, busy);
   modport master (output in_valid, in_idx, ack, input in_ready, grant, done, err_timeout, err_range, busy);
endinterface

// File: rtl/decoder_dispatch_2x4_onehot_decode.sv
// decoder_dispatch_2x4_onehot_decode: W-to-N one-hot decode; all-zero output flags an out-of-range index
module decoder_dispatch_2x4_onehot_decode #(parameter int N = 4, parameter int W = 2) (
   input  logic [W-1:0] idx_i,
   output logic [N-1:0] onehot_o,
   output logic         in_range_o
);
   always_comb begin
      onehot_o = '0;
      for (int i = 0; i < N; i++) onehot_o[i] = idx_i == W'(i);
   end
   assign in_range_o = |onehot_o;
endmodule

// File: rtl/decoder_dispatch_2x4.sv
// decoder_dispatch_2x4: registered one-hot grant dispatcher with ack/release handshake and timeout
module decoder_dispatch_2x4
   import decoder_dispatch_2x4_pkg::*;
#(
   parameter int N = N_DEF,
   parameter int W = W_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF,
   parameter int TW = TW_DEF
) (
   input logic clk,
   input logic rst_n,
   decoder_dispatch_2x4_if.slave dd
);
   state_e state_q, state_d;
   logic [N-1:0] grant_q, grant_d, dec_onehot;
   logic [W-1:0] sel_q, sel_d;
   logic [TW-1:0] cnt_q, cnt_d;
   logic done_q, done_d, err_timeout_q, err_timeout_d, err_range_q, err_range_d, tmo_q, tmo_d;
   logic in_range, accept, ack_sel, timeout_hit, in_grant;
   decoder_dispatch_2x4_onehot_decode #(.N(N), .W(W)) u_dec (
      .idx_i(dd.in_idx),
      .onehot_o(dec_onehot),
      .in_range_o(in_range)
   );
   always_comb begin
      ack_sel = 1'b0;
      for (int i = 0; i < N; i++) if (sel_q == W'(i)) ack_sel = dd.ack[i];
   end
   assign accept = dd.in_valid && state_q == IDLE;
   assign timeout_hit = cnt_q == TW'(TIMEOUT - 1);
   assign in_grant = state_q == GRANT;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         grant_q <= '0;
         sel_q <= '0;
         cnt_q <= '0;
         done_q <= 1'b0;
         err_timeout_q <= 1'b0;
         err_range_q <= 1'b0;
         tmo_q <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         sel_q <= sel_d;
         cnt_q <= cnt_d;
         done_q <= done_d;
         err_timeout_q <= err_timeout_d;
         err_range_q <= err_range_d;
         tmo_q <= tmo_d;
      end
   end
   // ack beats timeout when both land on the same cycle
   always_comb begin
      state_d = state_q == IDLE  ? ((accept && in_range) ? GRANT : IDLE) :
                in_grant         ? ((ack_sel || timeout_hit) ? RELEASE : GRANT) :
                ack_sel          ? RELEASE : IDLE;
   end
   always_comb begin
      grant_d = state_q == IDLE ? (accept ? dec_onehot : '0) :
                (in_grant && !ack_sel && !timeout_hit) ? grant_q : '0;
      cnt_d = in_grant ? (timeout_hit ? cnt_q : cnt_q + TW'(1)) : '0;
      sel_d = accept ? dd.in_idx : sel_q;
      err_range_d = accept && !in_range;
      err_timeout_d = in_grant && !ack_sel && timeout_hit;
      tmo_d = in_grant ? (!ack_sel && timeout_hit) : tmo_q;
      done_d = state_q == RELEASE && !ack_sel && !tmo_q;
   end
   always_comb begin
      dd.in_ready = state_q == IDLE;
      dd.busy = state_q != IDLE;
      dd.grant = grant_q;
      dd.done = done_q;
      dd.err_timeout = err_timeout_q;
      dd.err_range = err_range_q;
   end
endmodule

// File: tb/tb_decoder_dispatch_2x4.sv
// tb_decoder_dispatch_2x4: table-driven transactions with an expectation queue, plus reset and N=3 sequences
module tb_decoder_dispatch_2x4;
   localparam int NEVER = 255;
   typedef struct {
      int idx; logic [3:0] bg; int dly; int hold; bit pre; bit noise;
      logic [3:0] e_grant; int e_gcyc; int e_busy; int e_done; int e_tmo; int e_rng;
   } vec_t;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int n_vec = 0, n_cmp = 0, n_err = 0;
   vec_t exp_q[$];
   vec_t tbl[10];
   always #5 clk = ~clk;
   decoder_dispatch_2x4_if #(.N(4), .W(2)) bus ();
   decoder_dispatch_2x4_if #(.N(3), .W(2)) bus3 ();
   decoder_dispatch_2x4 #(.N(4), .W(2), .TIMEOUT(15), .TW(8)) dut (.clk(clk), .rst_n(rst_n), .dd(bus));
   decoder_dispatch_2x4 #(.N(3), .W(2), .TIMEOUT(15), .TW(8)) dut3 (.clk(clk), .rst_n(rst_n), .dd(bus3));
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   // k counts cycles since grant was first seen; ack edges are scheduled against it
   task automatic apply(input vec_t v);
      vec_t e;
      logic [3:0] gval = '0;
      int gcyc = 0, bcyc = 0, dn = 0, tm = 0, rg = 0, multi = 0, rdy_bad = 0, k = -1, idle_run = 0;
      bit fin = 0;
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_idx = 2'(v.idx);
      bus.ack = v.bg | (v.pre ? 4'(1) << v.idx : 4'b0);
      exp_q.push_back(v);
      n_vec++;
      for (int c = 0; c < 60 && !fin; c++) begin
         @(negedge clk);
         bus.in_valid = 1'b0;
         if (k >= 0) k++;
         else if (bus.grant != 0) begin
            k = 0;
            gval = bus.grant;
         end
         if (bus.grant != 0) begin
            gcyc++;
            if (!$onehot(bus.grant) || bus.grant != gval) multi++;
         end
         bcyc += int'(bus.busy);
         dn += int'(bus.done);
         tm += int'(bus.err_timeout);
         rg += int'(bus.err_range);
         if (bus.in_ready === bus.busy) rdy_bad++;
         if (k >= 0 && !v.pre && k == v.dly) bus.ack[v.idx] = 1'b1;
         if (k >= 0 && k == v.dly + v.hold) bus.ack[v.idx] = 1'b0;
         if (v.noise && bus.busy) begin
            bus.in_valid = (c % 2) == 0;
            bus.in_idx = 2'd2;
         end
         idle_run = bus.busy ? 0 : idle_run + 1;
         fin = idle_run >= 3 && c >= 3;
      end
      chk($sformatf("v%0d bound", n_vec), 32'(fin), 1);
      bus.ack = '0;
      bus.in_valid = 1'b0;
      e = exp_q.pop_front();
      chk($sformatf("v%0d grant", n_vec), 32'(gval), 32'(e.e_grant));
      chk($sformatf("v%0d grant_cycles", n_vec), gcyc, e.e_gcyc);
      chk($sformatf("v%0d busy_cycles", n_vec), bcyc, e.e_busy);
      chk($sformatf("v%0d done", n_vec), dn, e.e_done);
      chk($sformatf("v%0d err_timeout", n_vec), tm, e.e_tmo);
      chk($sformatf("v%0d err_range", n_vec), rg, e.e_rng);
      chk($sformatf("v%0d onehot", n_vec), multi, 0);
      chk($sformatf("v%0d in_ready", n_vec), rdy_bad, 0);
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end
   initial begin
      bus.in_valid = 1'b0; bus.in_idx = '0; bus.ack = '0;
      bus3.in_valid = 1'b0; bus3.in_idx = '0; bus3.ack = '0;
      repeat (2) @(negedge clk);
      chk("rst grant", 32'(bus.grant), 0);
      chk("rst busy", 32'(bus.busy), 0);
      chk("rst in_ready", 32'(bus.in_ready), 1);
      chk("rst pulses", 32'({bus.done, bus.err_timeout, bus.err_range}), 0);
      rst_n = 1'b1;
      tbl[0] = '{2, 4'b0000, 1,     1, 0, 0, 4'b0100,  2,  3, 1, 0, 0};
      tbl[1] = '{0, 4'b0000, 0,     1, 0, 0, 4'b0001,  1,  2, 1, 0, 0};
      tbl[2] = '{1, 4'b0000, 0,     1, 0, 0, 4'b0010,  1,  2, 1, 0, 0};
      tbl[3] = '{2, 4'b0000, 0,     1, 0, 0, 4'b0100,  1,  2, 1, 0, 0};
      tbl[4] = '{3, 4'b0000, 0,     1, 0, 0, 4'b1000,  1,  2, 1, 0, 0};
      tbl[5] = '{1, 4'b0000, NEVER, 1, 0, 0, 4'b0010, 15, 16, 0, 1, 0};
      tbl[6] = '{0, 4'b1000, 3,     1, 0, 1, 4'b0001,  4,  5, 1, 0, 0};
      tbl[7] = '{3, 4'b0000, 14,    2, 0, 0, 4'b1000, 15, 17, 1, 0, 0};
      tbl[8] = '{2, 4'b0000, 0,     2, 1, 0, 4'b0100,  1,  3, 1, 0, 0};
      tbl[9] = '{1, 4'b0000, 2,     5, 0, 0, 4'b0010,  3,  8, 1, 0, 0};
      for (int i = 0; i < 10; i++) apply(tbl[i]);
      // out-of-range index on the N=3 instance, then a normal grant there
      @(negedge clk);
      bus3.in_valid = 1'b1; bus3.in_idx = 2'd3; n_vec++;
      @(negedge clk);
      bus3.in_valid = 1'b0;
      chk("n3 err_range", 32'(bus3.err_range), 1);
      chk("n3 grant", 32'(bus3.grant), 0);
      chk("n3 busy", 32'(bus3.busy), 0);
      @(negedge clk);
      chk("n3 err_range pulse", 32'(bus3.err_range), 0);
      chk("n3 idle grant", 32'(bus3.grant), 0);
      bus3.in_valid = 1'b1; bus3.in_idx = 2'd2; n_vec++;
      @(negedge clk);
      bus3.in_valid = 1'b0;
      chk("n3 grant2", 32'(bus3.grant), 32'b100);
      bus3.ack = 3'b100;
      @(negedge clk);
      chk("n3 release grant", 32'(bus3.grant), 0);
      chk("n3 release busy", 32'(bus3.busy), 1);
      bus3.ack = 3'b000;
      @(negedge clk);
      chk("n3 done", 32'(bus3.done), 1);
      chk("n3 idle busy", 32'(bus3.busy), 0);
      // asynchronous reset two cycles into GRANT
      @(negedge clk);
      bus.in_valid = 1'b1; bus.in_idx = 2'd3; n_vec++;
      @(negedge clk);
      bus.in_valid = 1'b0;
      chk("mid grant1", 32'(bus.grant), 32'b1000);
      @(negedge clk);
      chk("mid grant2", 32'(bus.grant), 32'b1000);
      #2 rst_n = 1'b0;
      #1;
      chk("async grant", 32'(bus.grant), 0);
      chk("async busy", 32'(bus.busy), 0);
      chk("async in_ready", 32'(bus.in_ready), 1);
      @(negedge clk);
      chk("async pulses", 32'({bus.done, bus.err_timeout, bus.err_range}), 0);
      rst_n = 1'b1;
      apply(tbl[2]);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
